// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two valid/ready requesters share a one-word output register.
// When both requesters want the register, they take turns. Each source has
// a counter of accepted transfers that stops at its maximum value.
//
// state  | meaning
// -------+---------------------------------------------
// EMPTY  | output register holds no valid word
// FULL_A | output register holds a word taken from A
// FULL_B | output register holds a word taken from B
module mux2_arbiter #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  a,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [N-1:0]  b,
    input  logic          b_valid,
    output logic          b_ready,
    output logic [N-1:0]  y,
    output logic          y_valid,
    input  logic          y_ready,
    output logic          sel,
    output logic [CW-1:0] a_count,
    output logic [CW-1:0] b_count
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL_A = 2'd1,
        FULL_B = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  y_q, y_d;
    logic          last_a_q, last_a_d;   // 1: last grant went to A, 0: to B
    logic [CW-1:0] a_count_q, a_count_d;
    logic [CW-1:0] b_count_q, b_count_d;

    logic accept;
    logic grant_a;
    logic grant_b;

    // Handshake: the register can take a word when it is empty or being drained.
    // Grants depend only on valids and the turn pointer, never on data.
    // Ready is gated by rst so nothing is accepted while the block is held in reset.
    always_comb begin
        accept  = (state_q == EMPTY) || (y_valid && y_ready);
        grant_a = a_valid && (!b_valid || !last_a_q);
        grant_b = b_valid && (!a_valid ||  last_a_q);
        a_ready = accept && grant_a && !rst;
        b_ready = accept && grant_b && !rst;
    end

    // Next-state logic for the output register, its source and the turn pointer.
    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        last_a_d = last_a_q;
        if (accept) begin
            if (grant_a) begin
                state_d  = FULL_A;
                y_d      = a;
                last_a_d = 1'b1;
            end else if (grant_b) begin
                state_d  = FULL_B;
                y_d      = b;
                last_a_d = 1'b0;
            end else begin
                // Drained with nothing to refill: word stays in y but is no longer valid.
                state_d = EMPTY;
            end
        end
    end

    // Transfer counters stick at all-ones rather than wrapping.
    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (a_ready && (a_count_q != {CW{1'b1}})) begin
            a_count_d = a_count_q + CW'(1);
        end
        if (b_ready && (b_count_q != {CW{1'b1}})) begin
            b_count_d = b_count_q + CW'(1);
        end
    end

    // State register; reset drops any held word at once and hands the first
    // contention to A by recording B as the last grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            y_q       <= '0;
            last_a_q  <= 1'b0;
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            last_a_q  <= last_a_d;
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    // Outputs decoded directly from registered state.
    always_comb begin
        y       = y_q;
        y_valid = (state_q == FULL_A) || (state_q == FULL_B);
        sel     = (state_q == FULL_A);
        a_count = a_count_q;
        b_count = b_count_q;
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: a default-width instance plus a CW=2
// instance driven by the same stimulus to see counter saturation.
module tb_mux2_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         a_valid = 1'b0;
    logic         b_valid = 1'b0;
    logic         y_ready = 1'b0;

    logic         a_ready, b_ready, y_valid, sel;
    logic [N-1:0] y;
    logic [7:0]   a_count, b_count;

    logic         s_a_ready, s_b_ready, s_y_valid, s_sel;
    logic [N-1:0] s_y;
    logic [1:0]   s_a_count, s_b_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp_y34 [4];
    logic       exp_s34 [4];
    logic [3:0] b_seq   [3];

    mux2_arbiter #(.N(N), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .a(a), .a_valid(a_valid), .a_ready(a_ready),
        .b(b), .b_valid(b_valid), .b_ready(b_ready),
        .y(y), .y_valid(y_valid), .y_ready(y_ready), .sel(sel),
        .a_count(a_count), .b_count(b_count)
    );

    mux2_arbiter #(.N(N), .CW(2)) dut_small (
        .clk(clk), .rst(rst),
        .a(a), .a_valid(a_valid), .a_ready(s_a_ready),
        .b(b), .b_valid(b_valid), .b_ready(s_b_ready),
        .y(s_y), .y_valid(s_y_valid), .y_ready(y_ready), .sel(s_sel),
        .a_count(s_a_count), .b_count(s_b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_y34 = '{4'h3, 4'hC, 4'h3, 4'hC};
        exp_s34 = '{1'b1, 1'b0, 1'b1, 1'b0};
        b_seq   = '{4'h9, 4'hA, 4'hB};

        // Reset state, readies held low during reset even with a request pending
        #1 rst = 1'b1;
        #1;
        chk("rst_y",       y,       0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_sel",     sel,     0);
        chk("rst_a_count", a_count, 0);
        chk("rst_b_count", b_count, 0);
        a_valid = 1'b1;
        #1;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        tick();
        chk("rst_hold_y_valid", y_valid, 0);
        rst = 1'b0;
        a_valid = 1'b0;
        tick();

        // Contention with a continuous drain: strict alternation starting with A
        a = 4'h3; b = 4'hC; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_a_ready%0d", i), a_ready, exp_s34[i]);
            chk($sformatf("rr_b_ready%0d", i), b_ready, !exp_s34[i]);
            tick();
            chk($sformatf("rr_y%0d", i),       y,       exp_y34[i]);
            chk($sformatf("rr_sel%0d", i),     sel,     exp_s34[i]);
            chk($sformatf("rr_y_valid%0d", i), y_valid, 1);
        end
        chk("rr_a_count", a_count, 2);
        chk("rr_b_count", b_count, 2);

        // Valids drop while draining: register empties, y keeps last word
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        chk("drop_y_valid", y_valid, 0);
        chk("drop_y",       y,       4'hC);

        // A alone with a stalled consumer: one accept, then held
        a = 4'h5; a_valid = 1'b1; y_ready = 1'b0;
        #1;
        chk("stall_first_a_ready", a_ready, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall_a_ready%0d", i), a_ready, 0);
            chk($sformatf("stall_y%0d", i),       y,       4'h5);
            chk($sformatf("stall_sel%0d", i),     sel,     1);
            chk($sformatf("stall_valid%0d", i),   y_valid, 1);
            tick();
        end
        chk("stall_a_count", a_count, 3);

        // Release the stall with no further requests: back to EMPTY, pointer stays A
        a_valid = 1'b0; y_ready = 1'b1;
        tick();
        chk("idle_y_valid", y_valid, 0);
        chk("idle_y",       y,       4'h5);
        tick();
        tick();
        a = 4'h3; b = 4'hC; a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("ptr_kept_b_ready", b_ready, 1);
        chk("ptr_kept_a_ready", a_ready, 0);
        tick();
        chk("ptr_kept_y",   y,   4'hC);
        chk("ptr_kept_sel", sel, 0);

        // B alone for three cycles: granted every cycle, no bubble
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b = b_seq[i];
            #1;
            chk($sformatf("bonly_b_ready%0d", i), b_ready, 1);
            tick();
            chk($sformatf("bonly_y%0d", i),     y,       b_seq[i]);
            chk($sformatf("bonly_valid%0d", i), y_valid, 1);
            chk($sformatf("bonly_sel%0d", i),   sel,     0);
        end
        chk("bonly_b_count", b_count, 6);
        chk("bonly_a_count", a_count, 3);

        // Fresh reset, then five A-only transfers: CW=2 counter sticks at 3
        b_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 4'(i + 1);
            tick();
            chk($sformatf("sat_y%0d", i),       s_y,       i + 1);
            chk($sformatf("sat_a_count%0d", i), s_a_count, (i < 3) ? i + 1 : 3);
            chk($sformatf("sat_b_count%0d", i), s_b_count, 0);
        end
        chk("sat_wide_a_count", a_count, 5);

        // Fill from B, stall, then reset mid-cycle: word dropped without a clock edge
        a_valid = 1'b0; b = 4'h6; b_valid = 1'b1;
        tick();
        chk("fb_y",   y,   4'h6);
        chk("fb_sel", sel, 0);
        b_valid = 1'b0; y_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("async_y_valid", y_valid, 0);
        chk("async_y",       y,       0);
        chk("async_b_count", b_count, 0);
        tick();
        rst = 1'b0;
        a = 4'h7; b = 4'h8; a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("post_rst_a_ready", a_ready, 1);
        chk("post_rst_b_ready", b_ready, 0);
        tick();
        chk("post_rst_y",   y,   4'h7);
        chk("post_rst_sel", sel, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter N, default 4, data word width in bits.
REQ-002 Parameter CW, default 8, width of each transfer counter.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a  input  N  requester A data word.
REQ-006 a_valid  input  1  requester A holds a word for transfer.
REQ-007 a_ready  output  1  A's word accepted this cycle.
REQ-008 b  input  N  requester B data word.
REQ-009 b_valid  input  1  requester B holds a word for transfer.
REQ-010 b_ready  output  1  B's word accepted this cycle.
REQ-011 y  output  N  registered output word.
REQ-012 y_valid  output  1  y holds a valid word.
REQ-013 y_ready  input  1  downstream consumes y this cycle.
REQ-014 sel  output  1  source of the word in y: 1 = A, 0 = B (matches mux2to1 select sense).
REQ-015 a_count, b_count  output  CW each  transfers accepted from A and from B.

Function
REQ-016 A one-word output register is controlled by a 3-state FSM: EMPTY, FULL_A, FULL_B.
REQ-017 y_valid is 1 in FULL_A or FULL_B and 0 in EMPTY; sel is 1 in FULL_A and 0 otherwise.
REQ-018 accept = (state==EMPTY) or (y_valid and y_ready), combinational.
REQ-019 Grant rules when accept=1: only a_valid -> grant A; only b_valid -> grant B; both -> grant the requester not granted last (round-robin); neither -> no grant.
REQ-020 a_ready = accept and grant A; b_ready = accept and grant B; both are combinational; a_ready and b_ready are never 1 together.
REQ-021 On a grant to A: y <= a, next state FULL_A. On a grant to B: y <= b, next state FULL_B. Both take effect at the next posedge.
REQ-022 If accept=1 with no grant and the register is being consumed, the next state is EMPTY; y keeps its old value.
REQ-023 If y_valid=1 and y_ready=0, the state, y and sel are held; a_ready=b_ready=0.
REQ-024 Consume plus refill in the same cycle gives full throughput: one word per cycle with no bubble.
REQ-025 Latency from an accepted request (ready=1) to y_valid=1 is exactly 1 cycle.
REQ-026 The last-grant pointer updates only on a grant; it never changes while idle or stalled.
REQ-027 Counters increment by 1 on the matching ready; they saturate at 2^CW-1 and never wrap.
REQ-028 valid/ready ports are not registered; no combinational path exists from a or b data to any ready.
REQ-029 Requesters keep their valid and data stable until they see ready; the block does not check this.

Reset
REQ-030 While rst=1: state=EMPTY, y=0, y_valid=0, sel=0, a_count=0, b_count=0.
REQ-031 While rst=1, the last-grant pointer is set to B, so A wins the first contention after reset.
REQ-032 Reset asserted mid-transfer discards the held word immediately, without waiting for a clock edge.
REQ-033 a_ready=b_ready=0 while rst=1.

Verification
REQ-034 Reset release, then a_valid=b_valid=1, a=4'h3, b=4'hC, y_ready=1 for 4 cycles -> y sequence 3,C,3,C; sel sequence 1,0,1,0; a_count=2; b_count=2.
REQ-035 a_valid=1, a=4'h5, b_valid=0, y_ready=0 -> y=5, sel=1, y_valid=1 held; a_ready=0 on every cycle after the first accept until y_ready=1.
REQ-036 Only b_valid=1 for 3 cycles with y_ready=1 -> B granted each cycle (no forced alternation); b_count=3; y_valid stays high continuously.
REQ-037 With CW=2, 5 A-only transfers -> a_count saturates at 3 and b_count stays 0.
REQ-038 rst pulsed while state=FULL_B and y_ready=0 -> y_valid=0 and y=0 immediately; the next contention grants A.
REQ-039 Valids drop while y_ready=1 -> FSM returns to EMPTY; y_valid=0; the pointer keeps the last grant.
